// File: rtl/apb_requester.sv
// apb_requester: turns single local commands into APB SETUP/ACCESS transfers
// with wait states, PSLVERR, byte strobes and a bus-hang timeout.
module apb_requester #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 16,
    localparam int StrbWidth    = DataWidth / 8
) (
    input  logic                 PCLK,
    input  logic                 reset,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic                 CmdWrite,
    input  logic [AddrWidth-1:0] CmdAddr,
    input  logic [DataWidth-1:0] CmdWData,
    input  logic [StrbWidth-1:0] CmdStrb,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DataWidth-1:0] RspRData,
    output logic                 RspError,
    output logic                 RspTimeout,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [AddrWidth-1:0] PADDR,
    output logic [DataWidth-1:0] PWDATA,
    output logic [StrbWidth-1:0] PSTRB,
    input  logic [DataWidth-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);
    localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state;
    logic [CntWidth-1:0] wait_cnt;

    assign CmdReady = (state == IDLE);

    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            RspValid   <= 1'b0;
            RspRData   <= '0;
            RspError   <= 1'b0;
            RspTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (CmdValid) begin
                    PWRITE   <= CmdWrite;
                    PADDR    <= CmdAddr;
                    PSTRB    <= CmdWrite ? CmdStrb : '0;
                    PSEL     <= 1'b1;
                    wait_cnt <= '0;
                    state    <= SETUP;
                    if (CmdWrite) PWDATA <= CmdWData;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: if (PREADY) begin
                    PSEL       <= 1'b0;
                    PENABLE    <= 1'b0;
                    RspRData   <= PWRITE ? '0 : PRDATA;
                    RspError   <= PSLVERR;
                    RspTimeout <= 1'b0;
                    RspValid   <= 1'b1;
                    state      <= RESP;
                end else if (TimeoutCycles != 0 && wait_cnt == CntLast) begin
                    PSEL       <= 1'b0;
                    PENABLE    <= 1'b0;
                    RspRData   <= '0;
                    RspError   <= 1'b1;
                    RspTimeout <= 1'b1;
                    RspValid   <= 1'b1;
                    state      <= RESP;
                end else if (wait_cnt != '1) begin
                    // saturate so a disabled timeout never wraps the counter
                    wait_cnt <= wait_cnt + CntWidth'(1);
                end
                RESP: if (RspReady) begin
                    RspValid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed and randomized transfers against a cycle-count
// reference model of the APB requester, with a scripted completer.
module tb_apb_requester;
    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        reset = 1'b1;
    logic        CmdValid = 1'b0, CmdWrite = 1'b0;
    logic [31:0] CmdAddr = '0, CmdWData = '0;
    logic [3:0]  CmdStrb = '0;
    logic        CmdReady, RspValid, RspError, RspTimeout;
    logic        RspReady = 1'b1;
    logic [31:0] RspRData;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    apb_requester #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(TO)) dut (
        .PCLK(PCLK), .reset(reset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
        .CmdAddr(CmdAddr), .CmdWData(CmdWData), .CmdStrb(CmdStrb),
        .RspValid(RspValid), .RspReady(RspReady), .RspRData(RspRData),
        .RspError(RspError), .RspTimeout(RspTimeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command end to end; expected timing comes from the wait/timeout rules:
    // ACCESS lasts waits+1 cycles (or TO on timeout) and the response follows it.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input bit slverr,
                        input logic [31:0] rdata, input int rsp_wait);
        bit          to      = (waits >= TO);
        int          ac_exp  = to ? TO : waits + 1;
        logic [31:0] exp_rd  = (wr || to) ? 32'h0 : rdata;
        bit          exp_err = to || slverr;
        int ac = 0, psel_n = 0, psel_first = 0, pen_first = 0, rsp_cyc = 0;
        @(negedge PCLK);
        chk("cmd_ready_idle", CmdReady, 1);
        CmdValid = 1'b1; CmdWrite = wr; CmdAddr = addr; CmdWData = wdata; CmdStrb = strb;
        RspReady = 1'b0; PREADY = 1'($urandom_range(0, 1));
        @(posedge PCLK);
        for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
            @(negedge PCLK);
            chk("pen_without_psel", PENABLE & ~PSEL, 0);
            chk("cmd_ready_busy", CmdReady, 0);
            if (PSEL) begin
                psel_n++;
                if (psel_first == 0) psel_first = c;
                chk("paddr", PADDR, addr);
                chk("pwrite", PWRITE, wr);
                chk("pstrb", PSTRB, wr ? strb : 4'h0);
                if (wr) chk("pwdata", PWDATA, wdata);
            end
            if (PENABLE) begin
                ac++;
                if (pen_first == 0) pen_first = c;
            end
            if (RspValid) rsp_cyc = c;
            PREADY  = PENABLE ? (ac == waits + 1) : 1'($urandom_range(0, 1));
            PRDATA  = (PENABLE && PREADY) ? rdata : $urandom;
            PSLVERR = (PENABLE && PREADY) ? slverr : 1'($urandom_range(0, 1));
        end
        CmdValid = 1'b0;
        chk("psel_first", psel_first, 1);
        chk("pen_first", pen_first, 2);
        chk("psel_cycles", psel_n, ac_exp + 1);
        chk("access_cycles", ac, ac_exp);
        chk("rsp_latency", rsp_cyc, 2 + ac_exp);
        chk("rsp_rdata", RspRData, exp_rd);
        chk("rsp_error", RspError, exp_err);
        chk("rsp_timeout", RspTimeout, to);
        chk("psel_after", PSEL, 0);
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge PCLK);
            chk("hold_valid", RspValid, 1);
            chk("hold_rdata", RspRData, exp_rd);
            chk("hold_error", RspError, exp_err);
            chk("hold_timeout", RspTimeout, to);
            chk("hold_cmd_ready", CmdReady, 0);
        end
        RspReady = 1'b1;
        @(negedge PCLK);
        chk("rsp_drop", RspValid, 0);
        chk("cmd_ready_back", CmdReady, 1);
        RspReady = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pstrb", PSTRB, 0);
        chk("rst_rsp_valid", RspValid, 0);
        chk("rst_rsp_rdata", RspRData, 0);
        chk("rst_rsp_error", RspError, 0);
        chk("rst_rsp_timeout", RspTimeout, 0);
        chk("rst_cmd_ready", CmdReady, 1);
        @(negedge PCLK);
        reset = 1'b0;

        xfer(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0, 0);
        xfer(1'b0, 32'h24, 32'h1111_2222, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 0);
        xfer(1'b1, 32'h30, 32'h0BAD_F00D, 4'h5, 2, 1'b1, 32'h0, 1);
        xfer(1'b1, 32'h34, 32'h1234_5678, 4'h3, 4, 1'b0, 32'h0, 0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, TO, 1'b0, 32'hCAFE_0001, 0);
        xfer(1'b0, 32'h44, 32'h0, 4'h0, 1, 1'b0, 32'h7777_8888, 0);
        xfer(1'b0, 32'h48, 32'h0, 4'h0, 0, 1'b1, 32'h5555_AAAA, 5);

        for (int i = 0; i < 25; i++)
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                 int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)), $urandom,
                 int'($urandom_range(0, 3)));

        // reset in the middle of ACCESS
        @(negedge PCLK);
        CmdValid = 1'b1; CmdWrite = 1'b1; CmdAddr = 32'h88; PREADY = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        CmdValid = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("mid_penable", PENABLE, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_psel", PSEL, 0);
        chk("async_penable", PENABLE, 0);
        @(negedge PCLK);
        reset = 1'b0;
        RspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("no_rsp_after_reset", RspValid, 0);
            chk("idle_after_reset", CmdReady, 1);
        end
        xfer(1'b0, 32'h90, 32'h0, 4'h0, 0, 1'b0, 32'h0102_0304, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (master) that turns single commands from a local valid/ready port into APB SETUP/ACCESS transfers. It is the initiating end of the APB links terminated by the team's completer blocks. It handles wait states, PSLVERR, byte strobes and a bus-hang timeout. One transfer is outstanding at a time, and the result is returned on a valid/ready response port.

## Interface
- DataWidth, 32, data bus width; multiple of 8
- AddrWidth, 32, address bus width
- TimeoutCycles, 16, max ACCESS cycles without PREADY before abort; 0 disables timeout
- StrbWidth (localparam) = DataWidth/8

Ports:
- PCLK  in  1  APB clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- CmdValid  in  1  command request
- CmdReady  out  1  command accepted when CmdValid && CmdReady at an edge
- CmdWrite  in  1  1 = write, 0 = read
- CmdAddr  in  AddrWidth  transfer address
- CmdWData  in  DataWidth  write data
- CmdStrb  in  StrbWidth  write byte strobes
- RspValid  out  1  response available
- RspReady  in  1  response consumed when RspValid && RspReady at an edge
- RspRData  out  DataWidth  read data; 0 for writes and timeouts
- RspError  out  1  PSLVERR seen, or timeout
- RspTimeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  AddrWidth;  PWDATA  out  DataWidth;  PSTRB  out  StrbWidth
- PRDATA  in  DataWidth;  PREADY  in  1;  PSLVERR  in  1

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP. Reset state is IDLE. All outputs are registered except CmdReady = (state == IDLE).
- IDLE: if CmdValid, perform the following, then go to SETUP:
  - latch CmdWrite into PWRITE and CmdAddr into PADDR;
  - latch CmdWData into PWDATA for writes;
  - set PSTRB = CmdStrb for writes, and force PSTRB = 0 for reads;
  - set PSEL = 1.
- SETUP: PSEL = 1, PENABLE = 0 for exactly one cycle. PREADY is ignored. Then set PENABLE = 1 and go to ACCESS.
- ACCESS: PSEL = PENABLE = 1; wait counter increments each cycle PREADY is low.
  - PREADY high: PSEL and PENABLE drop to 0. RspRData = PRDATA for reads, 0 for writes. RspError = PSLVERR, RspTimeout = 0. RspValid = 1. Go to RESP.
  - PREADY low and counter == TimeoutCycles-1 (TimeoutCycles != 0): abort. PSEL and PENABLE drop to 0. RspRData = 0, RspError = 1, RspTimeout = 1, RspValid = 1. Go to RESP.
- PSLVERR and PRDATA are sampled only on the completing edge (PSEL && PENABLE && PREADY).
- RESP: hold RspValid and response fields stable until RspReady. On the handshake edge, RspValid drops to 0 and the FSM goes to IDLE.
- PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the completing edge. They hold their last value while idle.
- Wait counter: width clog2(TimeoutCycles+1), minimum 1. Cleared on entry to SETUP. Never wraps.
- Commands presented outside IDLE are not accepted (CmdReady = 0). CmdValid may stay high across the busy period.

## Timing
- Reset values: PSEL = PENABLE = PWRITE = 0; PADDR, PWDATA, PSTRB = 0; RspValid = RspError = RspTimeout = 0; RspRData = 0; counter = 0. CmdReady = 1 (IDLE).
- Reset asserted mid-transfer: PSEL and PENABLE drop immediately (asynchronously), and any pending response is discarded.
- Accept at edge N: PSEL = 1 in cycle N+1; PENABLE = 1 in cycle N+2.
- Zero-wait completer (PREADY sampled high at edge N+2): RspValid = 1 in cycle N+3. Each PREADY-low cycle adds one cycle.
- Timeout: PENABLE is high for exactly TimeoutCycles cycles, then drops. RspValid rises on the next cycle.
- Response handshake at edge M: CmdReady = 1 in cycle M+1. With CmdValid held high, the next PSEL rises in cycle M+2.
- Minimum 4 cycles per transfer with RspReady tied high.
- PSEL never drops between SETUP and ACCESS. PENABLE is never high without PSEL.

## Test plan
- Reset: assert reset with RspReady = 1 -> all outputs 0 except CmdReady = 1. Release reset -> FSM in IDLE.
- Zero-wait write: addr 0x10, data 0xA5A5_1234, strb 0xF, PREADY = 1 -> PSEL for 2 cycles with PENABLE in the 2nd. PADDR, PWDATA and PSTRB stable throughout. RspValid 3 cycles after accept with RspError = 0 and RspRData = 0.
- Read with 3 wait states: PRDATA = 0xDEAD_BEEF when PREADY rises -> ACCESS lasts 4 cycles, PSTRB = 0, RspRData = 0xDEAD_BEEF.
- PSLVERR: write with PSLVERR = 1 on the completing edge -> RspError = 1 and RspTimeout = 0. A PSLVERR pulse during wait states has no effect.
- Timeout: TimeoutCycles = 16, PREADY stuck low -> PENABLE high for 16 cycles, then RspError = RspTimeout = 1 and RspRData = 0. The next command completes normally.
- Backpressure and reset: hold RspReady = 0 for 5 cycles -> response fields stable and CmdReady = 0 throughout. Assert reset during ACCESS -> PSEL and PENABLE drop at once, and no response follows.
